// File: rtl/rms_meansq_acc_if.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | rms_meansq_acc_if                                                           |
// | Sample / sqrt-handshake bundle for the RMS mean-square front end.           |
// | peak_o exists only when RMS_PEAK_HOLD_EN is defined.                        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
interface rms_meansq_acc_if;
  logic        clear_i;
  logic        sample_valid_i;
  logic [15:0] sample_i;
  logic        sqrt_valid_i;
  logic        ms_start_o;
  logic [39:0] ms_o;
  logic        window_done_o;
  logic        overrun_o;
`ifdef RMS_PEAK_HOLD_EN
  logic [15:0] peak_o;

  modport master (
    output clear_i, sample_valid_i, sample_i, sqrt_valid_i,
    input  ms_start_o, ms_o, window_done_o, overrun_o, peak_o
  );
  modport slave (
    input  clear_i, sample_valid_i, sample_i, sqrt_valid_i,
    output ms_start_o, ms_o, window_done_o, overrun_o, peak_o
  );
`else
  modport master (
    output clear_i, sample_valid_i, sample_i, sqrt_valid_i,
    input  ms_start_o, ms_o, window_done_o, overrun_o
  );
  modport slave (
    input  clear_i, sample_valid_i, sample_i, sqrt_valid_i,
    output ms_start_o, ms_o, window_done_o, overrun_o
  );
`endif
endinterface
`default_nettype wire

// File: rtl/rms_meansq_acc.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | rms_meansq_acc                                                              |
// | Squares signed 16-bit samples, averages them over 2^LOG2_N-sample windows   |
// | and issues the mean-square to the sqrt stage. Optional: RMS_PEAK_HOLD_EN.   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module rms_meansq_acc #(
  parameter int LOG2_N = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rms_meansq_acc_if.slave bus
);

  localparam int c_ACC_W = 31 + LOG2_N;

  generate
    if (LOG2_N < 1 || LOG2_N > 10) begin : g_bad_log2_n
      $error("rms_meansq_acc: LOG2_N must be within 1..10");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [30:0]         r_sq;
  logic                r_sq_vld;
  logic [c_ACC_W-1:0]  r_acc;
  logic [LOG2_N-1:0]   r_cnt;
  logic                r_start;
  logic                r_done;
  logic                r_overrun;
  logic [39:0]         r_ms;

  logic                w_accept;
  logic [15:0]         w_abs;
  logic [30:0]         w_sq;
  logic [c_ACC_W-1:0]  w_total;
  logic                w_close;
  logic                w_issue;

  assign w_accept = bus.sample_valid_i & ~bus.clear_i;
  // Magnitude is 16-bit unsigned so that |-32768| = 32768 stays exact
  assign w_abs    = bus.sample_i[15] ? (16'd0 - bus.sample_i) : bus.sample_i;
  assign w_sq     = 31'(w_abs) * 31'(w_abs);
  assign w_total  = r_acc + c_ACC_W'(r_sq);
  assign w_close  = r_sq_vld & (&r_cnt) & ~bus.clear_i;
  assign w_issue  = w_close & ((r_state == ST_IDLE) |
                               ((r_state == ST_WAIT) & bus.sqrt_valid_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_sq     <= '0;
      r_sq_vld <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (bus.clear_i) begin
      r_sq     <= '0;
      r_sq_vld <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      r_sq_vld <= w_accept;
      if (w_accept) begin
        r_sq <= w_sq;
      end
      if (r_sq_vld) begin
        r_cnt <= r_cnt + LOG2_N'(1);
        r_acc <= w_close ? '0 : w_total;
      end
    end
  end

  // Completion comes only from sqrt_valid_i; a close coincident with it issues
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= ST_IDLE;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_ms      <= '0;
    end else if (bus.clear_i) begin
      r_state   <= ST_IDLE;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_done  <= w_close;
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_close) begin
            r_ms    <= 40'(w_total >> LOG2_N);
            r_start <= 1'b1;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_state <= ST_WAIT;
          if (w_close) begin
            r_overrun <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (bus.sqrt_valid_i) begin
            if (w_close) begin
              r_ms    <= 40'(w_total >> LOG2_N);
              r_start <= 1'b1;
              r_state <= ST_ISSUE;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (w_close) begin
            r_overrun <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ms_start_o    = r_start;
  assign bus.ms_o          = r_ms;
  assign bus.window_done_o = r_done;
  assign bus.overrun_o     = r_overrun;

`ifdef RMS_PEAK_HOLD_EN
  logic [15:0] r_peak_trk;
  logic [15:0] r_peak;

  // A sample accepted in the close cycle already belongs to the next window
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_peak_trk <= '0;
      r_peak     <= '0;
    end else if (bus.clear_i) begin
      r_peak_trk <= '0;
    end else begin
      if (w_issue) begin
        r_peak <= r_peak_trk;
      end
      if (w_close) begin
        r_peak_trk <= w_accept ? w_abs : 16'd0;
      end else if (w_accept && (w_abs > r_peak_trk)) begin
        r_peak_trk <= w_abs;
      end
    end
  end

  assign bus.peak_o = r_peak;
`else
  logic w_issue_unused;
  assign w_issue_unused = w_issue;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rms_meansq_acc.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for rms_meansq_acc: directed table vectors, corner sequences and a
// randomized run checked cycle by cycle against a window-level reference model.
module tb_rms_meansq_acc;

  localparam int L = 8;
  localparam int N = 1 << L;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  rms_meansq_acc_if bus_if();

  rms_meansq_acc #(.LOG2_N(L)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus_if)
  );

  int compared   = 0;
  int mismatched = 0;

  // reference model state
  longint      m_sum, m_pend_total;
  int          m_cnt, m_pk, m_pend_pk;
  bit          m_pend, m_busy;
  bit          exp_start, exp_done, exp_over;
  logic [39:0] exp_ms;
  logic [15:0] exp_peak;

  // sqrt responder and observation
  int          resp_delay, resp_cnt;
  bit          force_sv;
  int          tick_no, n_start, n_done, last_start_tick, sv_tick;
  logic [39:0] cap_ms;
  logic [15:0] cap_peak;

  typedef struct {
    int          val;
    bit          alt;
    int          gap;
    logic [39:0] ms;
    int          peak;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_sum = 0; m_cnt = 0; m_pk = 0; m_pend = 0; m_busy = 0;
    m_pend_total = 0; m_pend_pk = 0;
    exp_start = 0; exp_done = 0; exp_over = 0; exp_ms = '0; exp_peak = '0;
  endfunction

  // Window rule: the close is seen one cycle after the N-th accepted sample;
  // it is issued when the sqrt stage is free, otherwise dropped.
  function automatic void model_step(input bit v, input logic [15:0] s, input bit sv, input bit clr);
    bit close_now, in_issue;
    int ss, a;
    if (clr) begin
      m_sum = 0; m_cnt = 0; m_pk = 0; m_pend = 0; m_busy = 0;
      exp_over = 0; exp_start = 0; exp_done = 0;
      return;
    end
    close_now = m_pend;
    in_issue  = exp_start;
    exp_done  = close_now;
    exp_start = 0;
    if (m_busy && !in_issue && sv) m_busy = 0;
    if (close_now) begin
      if (!m_busy) begin
        m_busy    = 1;
        exp_start = 1;
        exp_ms    = 40'(m_pend_total >> L);
        exp_peak  = 16'(m_pend_pk);
      end else begin
        exp_over = 1;
      end
    end
    m_pend = 0;
    if (v) begin
      ss = int'($signed(s));
      a  = (ss < 0) ? -ss : ss;
      m_sum += longint'(ss) * longint'(ss);
      if (a > m_pk) m_pk = a;
      m_cnt++;
      if (m_cnt == N) begin
        m_pend = 1; m_pend_total = m_sum; m_pend_pk = m_pk;
        m_sum = 0; m_cnt = 0; m_pk = 0;
      end
    end
  endfunction

  task automatic cmp_cycle();
    logic [42:0] act, exp;
    act = {bus_if.ms_start_o, bus_if.window_done_o, bus_if.overrun_o, bus_if.ms_o};
    exp = {exp_start, exp_done, exp_over, exp_ms};
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL cycle %0d start/done/ovr/ms: got %0b/%0b/%0b/%0d expected %0b/%0b/%0b/%0d",
               tick_no, act[42], act[41], act[40], act[39:0], exp[42], exp[41], exp[40], exp[39:0]);
    end
`ifdef RMS_PEAK_HOLD_EN
    check("peak_cycle", bus_if.peak_o, exp_peak);
`endif
  endtask

  task automatic tick(input bit v, input logic [15:0] s, input bit clr);
    bit sv;
    sv = force_sv || (resp_cnt == 1);
    if (resp_cnt > 0) resp_cnt--;
    bus_if.sample_valid_i = v;
    bus_if.sample_i       = s;
    bus_if.clear_i        = clr;
    bus_if.sqrt_valid_i   = sv;
    model_step(v, s, sv, clr);
    if (clr) resp_cnt = 0;
    @(negedge clk_i);
    tick_no++;
    cmp_cycle();
    if (bus_if.ms_start_o) begin
      n_start++;
      cap_ms = bus_if.ms_o;
      last_start_tick = tick_no;
`ifdef RMS_PEAK_HOLD_EN
      cap_peak = bus_if.peak_o;
`endif
    end
    if (bus_if.window_done_o) n_done++;
    if (exp_start && resp_delay > 0) resp_cnt = resp_delay + 1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    bus_if.sample_valid_i = 1'b0; bus_if.sample_i = '0;
    bus_if.clear_i = 1'b0; bus_if.sqrt_valid_i = 1'b0;
    model_reset();
    resp_cnt = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    cmp_cycle();
  endtask

  task automatic run_vec(input vec_t t);
    int s;
    resp_delay = 20;
    tick(0, '0, 1);
    n_start = 0; n_done = 0; cap_ms = '1;
    for (int i = 0; i < N; i++) begin
      s = (t.alt && i[0]) ? -t.val : t.val;
      tick(1, 16'(s), 0);
      for (int g = 0; g < t.gap; g++) tick(0, '0, 0);
    end
    repeat (40) tick(0, '0, 0);
    check("vec_ms", cap_ms, t.ms);
    check("vec_starts", n_start, 1);
    check("vec_window_done", n_done, 1);
    check("vec_overrun", bus_if.overrun_o, 0);
`ifdef RMS_PEAK_HOLD_EN
    check("vec_peak", cap_peak, t.peak);
`endif
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{val: 100,    alt: 0, gap: 0, ms: 40'd10000,      peak: 100};
    vecs[1] = '{val: -32768, alt: 0, gap: 0, ms: 40'd1073741824, peak: 32768};
    vecs[2] = '{val: 1000,   alt: 1, gap: 1, ms: 40'd1000000,    peak: 1000};
    vecs[3] = '{val: 32767,  alt: 0, gap: 0, ms: 40'd1073676289, peak: 32767};
    vecs[4] = '{val: 0,      alt: 0, gap: 0, ms: 40'd0,          peak: 0};
    vecs[5] = '{val: -5,     alt: 1, gap: 2, ms: 40'd25,         peak: 5};
    force_sv = 0; resp_delay = 20; tick_no = 0;
    n_start = 0; n_done = 0; last_start_tick = 0; sv_tick = 0;
    cap_ms = '0; cap_peak = '0;

    rst_i = 1'b0;
    @(negedge clk_i);
    do_reset();
    check("reset_ms", bus_if.ms_o, 0);
    check("reset_start", bus_if.ms_start_o, 0);
    check("reset_overrun", bus_if.overrun_o, 0);
    check("reset_done", bus_if.window_done_o, 0);

    foreach (vecs[k]) run_vec(vecs[k]);

    // sqrt withheld: second window dropped, sticky overrun, ms_o holds
    resp_delay = 0;
    tick(0, '0, 1);
    n_start = 0; n_done = 0;
    repeat (600) tick(1, 16'd3, 0);
    check("ovr_starts", n_start, 1);
    check("ovr_flag", bus_if.overrun_o, 1);
    check("ovr_ms_held", bus_if.ms_o, 9);
    check("ovr_done_count", n_done, 2);
    force_sv = 1;
    tick(1, 16'd3, 0);
    force_sv = 0;
    resp_delay = 20;
    repeat (300) tick(1, 16'd3, 0);
    check("ovr_next_issue", n_start, 2);
    check("ovr_next_ms", cap_ms, 9);
    check("ovr_sticky", bus_if.overrun_o, 1);

    // window close coincident with sqrt_valid_i
    resp_delay = 0;
    tick(0, '0, 1);
    n_start = 0;
    for (int i = 0; i < 520; i++) begin
      force_sv = (i == 512);
      tick(1, 16'd5, 0);
      if (i == 512) sv_tick = tick_no;
    end
    force_sv = 0;
    check("coinc_starts", n_start, 2);
    check("coinc_start_cycle", last_start_tick, sv_tick);
    check("coinc_overrun", bus_if.overrun_o, 0);

    // reset mid-window
    resp_delay = 20;
    tick(0, '0, 1);
    repeat (100) tick(1, 16'd50, 0);
    do_reset();
    n_start = 0;
    repeat (N - 1) tick(1, 16'd7, 0);
    repeat (5) tick(0, '0, 0);
    check("rst_no_early_start", n_start, 0);
    tick(1, 16'd7, 0);
    repeat (40) tick(0, '0, 0);
    check("rst_starts", n_start, 1);
    check("rst_ms", cap_ms, 49);

    // clear mid-window (ms_o holds across clear)
    repeat (100) tick(1, 16'd50, 0);
    tick(1, 16'd50, 1);
    n_start = 0;
    repeat (N - 1) tick(1, 16'd7, 0);
    repeat (5) tick(0, '0, 0);
    check("clr_no_early_start", n_start, 0);
    tick(1, 16'd7, 0);
    repeat (40) tick(0, '0, 0);
    check("clr_starts", n_start, 1);
    check("clr_ms", cap_ms, 49);

    // randomized traffic with varying sqrt latency, density and rare clears
    for (int p = 0; p < 8; p++) begin
      int dens;
      resp_delay = $urandom_range(3, 600);
      dens = $urandom_range(1, 3);
      for (int c = 0; c < 1500; c++) begin
        logic [15:0] s;
        bit v, clr;
        v = ($urandom_range(0, dens - 1) == 0);
        case ($urandom_range(0, 9))
          0:       s = 16'h8000;
          1:       s = 16'h7fff;
          2:       s = 16'(int'($urandom_range(0, 20)) - 10);
          default: s = 16'($urandom);
        endcase
        clr = ($urandom_range(0, 2999) == 0);
        tick(v, s, clr);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
